// File: rtl/router_rx_port.sv
// Serial input-port receiver: address capture, pad skip, LSB-first byte deserialiser, show-ahead FIFO.
// Optional statistics counters (pkt_cnt, byte_cnt) are built when RX_STATS_EN is defined.
module router_rx_port #(
  parameter int PAD_CYCLES = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        din,
  input  logic        frame_n,
  input  logic        valid_n,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic [3:0]  byte_da,
  output logic        byte_sop,
  output logic        byte_eop,
  output logic        err_frame,
  output logic        err_ovf,
`ifdef RX_STATS_EN
  output logic [15:0] pkt_cnt,
  output logic [31:0] byte_cnt,
`endif
  output logic [2:0]  dbg_state
);

  // Handshake: an entry moves when byte_valid && byte_ready at posedge clock;
  // once byte_valid is high it stays high, with a stable head, until that handshake.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_PAD  = 3'd2,
    S_DATA = 3'd3,
    S_DROP = 3'd4
  } state_e;

  state_e          state_q;
  logic [3:0]      da_q;
  logic [1:0]      acnt_q;
  logic [PW-1:0]   pcnt_q;
  logic [2:0]      idx_q;
  logic [6:0]      sreg_q;
  logic            sop_pend_q;
  logic            err_frame_q;
  logic            err_ovf_q;
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic [AW:0]     wr_ptr_d;
  logic [AW:0]     rd_ptr_d;
  logic [13:0]     mem_q [FIFO_DEPTH];

  logic            push_w;
  logic            pop_w;
  logic            full_w;
  logic            wr_en_w;
  logic [13:0]     push_ent_w;

  // The 8th bit bypasses the shift register so the byte lands in the FIFO on its own sampling edge.
  assign push_w     = (state_q == S_DATA) && !valid_n && (idx_q == 3'd7);
  assign push_ent_w = {da_q, sop_pend_q, frame_n, din, sreg_q};

  assign byte_valid = (wr_ptr_q != rd_ptr_q);
  assign pop_w      = byte_valid && byte_ready;
  assign full_w     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign wr_en_w    = push_w && (!full_w || pop_w);

  assign {byte_da, byte_sop, byte_eop, byte_data} = mem_q[rd_ptr_q[AW-1:0]];

  assign err_frame = err_frame_q;
  assign err_ovf   = err_ovf_q;
  assign dbg_state = state_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      da_q        <= 4'd0;
      acnt_q      <= 2'd0;
      pcnt_q      <= '0;
      idx_q       <= 3'd0;
      sreg_q      <= 7'd0;
      sop_pend_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      err_frame_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!frame_n) begin
            da_q    <= {da_q[3:1], din};
            acnt_q  <= 2'd1;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (frame_n || !valid_n) begin
            err_frame_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            da_q[acnt_q] <= din;
            if (acnt_q == 2'd3) begin
              pcnt_q     <= '0;
              idx_q      <= 3'd0;
              sop_pend_q <= 1'b1;
              if (PAD_CYCLES == 0) state_q <= S_DATA;
              else                 state_q <= S_PAD;
            end else begin
              acnt_q <= acnt_q + 2'd1;
            end
          end
        end
        S_PAD: begin
          if (frame_n) begin
            err_frame_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (!valid_n) begin
            err_frame_q <= 1'b1;
            state_q     <= S_DROP;
          end else if (pcnt_q == PW'(PAD_CYCLES - 1)) begin
            idx_q      <= 3'd0;
            sop_pend_q <= 1'b1;
            state_q    <= S_DATA;
          end else begin
            pcnt_q <= pcnt_q + PW'(1);
          end
        end
        S_DATA: begin
          if (!valid_n) begin
            if (idx_q == 3'd7) begin
              sop_pend_q <= 1'b0;
              idx_q      <= 3'd0;
              if (frame_n) state_q <= S_IDLE;
            end else if (frame_n) begin
              err_frame_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              sreg_q <= {din, sreg_q[6:1]};
              idx_q  <= idx_q + 3'd1;
            end
          end else if (frame_n) begin
            err_frame_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_DROP: begin
          if (frame_n) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_w) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_w)   rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_w && !wr_en_w) err_ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: byte_valid masks it until written.
  always_ff @(posedge clock) begin
    if (wr_en_w) mem_q[wr_ptr_q[AW-1:0]] <= push_ent_w;
  end

`ifdef RX_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [31:0] byte_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pkt_cnt_q  <= 16'd0;
      byte_cnt_q <= 32'd0;
    end else if (wr_en_w) begin
      byte_cnt_q <= byte_cnt_q + 32'd1;
      if (frame_n) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign byte_cnt = byte_cnt_q;
`endif

  a_head_hold: assert property (@(posedge clock) disable iff (!reset_n)
    (byte_valid && !byte_ready) |=> (byte_valid && $stable({byte_da, byte_sop, byte_eop, byte_data})));

endmodule

// File: tb/tb_router_rx_port.sv
// Bench for router_rx_port: packet-level expected-entry queue checked every cycle, plus literal pins.
module tb_router_rx_port;
  localparam int PAD   = 5;
  localparam int DEPTH = 8;

  // clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n = 1'b0, din = 1'b0, frame_n = 1'b1, valid_n = 1'b1, byte_ready = 1'b1;
  logic       byte_valid, byte_sop, byte_eop, err_frame, err_ovf;
  logic [7:0] byte_data;
  logic [3:0] byte_da;
  logic [2:0] dbg_state;
`ifdef RX_STATS_EN
  logic [15:0] pkt_cnt;
  logic [31:0] byte_cnt;
`endif

  router_rx_port #(.PAD_CYCLES(PAD), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .din(din), .frame_n(frame_n), .valid_n(valid_n),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data), .byte_da(byte_da),
    .byte_sop(byte_sop), .byte_eop(byte_eop), .err_frame(err_frame), .err_ovf(err_ovf),
`ifdef RX_STATS_EN
    .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt),
`endif
    .dbg_state(dbg_state)
  );

  int checks = 0, failures = 0, errs = 0;
  logic [13:0] exp_q[$];
  logic [13:0] got_q[$];
  logic [7:0]  pay_q[$];
  logic [13:0] mdl_ent = '0;
  bit mdl_push = 0, mdl_errf = 0, mdl_err = 0, mdl_ovf = 0, rst_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a bounded queue of {da,sop,eop,byte}; reset empties it, full-without-pop drops and flags.
  always @(posedge clock) begin
    bit pop, full;
    if (!reset_n) begin
      exp_q.delete();
      mdl_ovf  = 0;
      mdl_err  = 0;
      rst_seen = 1;
    end else begin
      pop  = (exp_q.size() != 0) && byte_ready;
      full = (exp_q.size() == DEPTH);
      if (pop) void'(exp_q.pop_front());
      if (mdl_push) begin
        if (!full || pop) exp_q.push_back(mdl_ent);
        else mdl_ovf = 1;
      end
      mdl_err = mdl_errf;
    end
  end

  // scoreboard compare, every cycle once reset has been applied
  always @(negedge clock) begin
    if (rst_seen) begin
      chk("valid", byte_valid, exp_q.size() != 0);
      if (exp_q.size() != 0 && byte_valid === 1'b1)
        chk("head", {byte_da, byte_sop, byte_eop, byte_data}, exp_q[0]);
      chk("err_frame", err_frame, mdl_err);
      chk("err_ovf", err_ovf, mdl_ovf);
      if (err_frame === 1'b1) errs++;
      if (byte_valid === 1'b1 && byte_ready === 1'b1)
        got_q.push_back({byte_da, byte_sop, byte_eop, byte_data});
    end
  end

  // driver tasks
  task automatic drive(input logic r, input logic f, input logic v, input logic d,
                       input bit p, input logic [13:0] e, input bit er);
    @(posedge clock);
    #1;
    reset_n  = r;
    frame_n  = f;
    valid_n  = v;
    din      = d;
    mdl_push = p;
    mdl_ent  = e;
    mdl_errf = er;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1, 1'b1, 1'b0, 0, '0, 0);
  endtask

  task automatic send_header(input logic [3:0] da);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, da[i], 0, '0, 0);
    repeat (PAD) drive(1'b1, 1'b0, 1'b1, 1'b0, 0, '0, 0);
  endtask

  task automatic send_packet(input logic [3:0] da, input int bub_bit, input int bub_n);
    int n;
    logic [7:0] bt;
    logic last;
    n = pay_q.size();
    send_header(da);
    for (int b = 0; b < n; b++) begin
      bt = pay_q[b];
      for (int i = 0; i < 8; i++) begin
        last = (b == n - 1) && (i == 7);
        drive(1'b1, last, 1'b0, bt[i], i == 7, {da, b == 0, b == n - 1, bt}, 0);
        if (b == 0 && i == bub_bit) repeat (bub_n) drive(1'b1, 1'b0, 1'b1, 1'b0, 0, '0, 0);
      end
    end
  endtask

  initial begin
    logic [7:0]  bt;
    logic [13:0] e;
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0, 0, '0, 0);
    idle(2);
    chk("rst_valid", byte_valid, 0);
    chk("rst_ovf", err_ovf, 0);

    // 1: two-byte packet
    got_q.delete(); errs = 0;
    pay_q = '{8'hA5, 8'h3C};
    send_packet(4'd5, -1, 0);
    idle(4);
    chk("t1_cnt", got_q.size(), 2);
    chk("t1_b0", got_q[0], {4'd5, 1'b1, 1'b0, 8'hA5});
    chk("t1_b1", got_q[1], {4'd5, 1'b0, 1'b1, 8'h3C});
    chk("t1_errs", errs, 0);

    // 2: back-to-back packets
    got_q.delete();
    pay_q = '{8'hFF};
    send_packet(4'd15, -1, 0);
    pay_q = '{8'h01};
    send_packet(4'd0, -1, 0);
    idle(4);
    chk("t2_cnt", got_q.size(), 2);
    chk("t2_b0", got_q[0], {4'd15, 1'b1, 1'b1, 8'hFF});
    chk("t2_b1", got_q[1], {4'd0, 1'b1, 1'b1, 8'h01});

    // 3: bubbles inside a byte, one-cycle latency
    got_q.delete();
    pay_q = '{8'h81};
    send_packet(4'd10, 2, 3);
    idle(1);
    @(negedge clock);
    chk("t3_lat_valid", byte_valid, 1);
    chk("t3_lat_data", byte_data, 8'h81);
    idle(3);
    chk("t3_cnt", got_q.size(), 1);
    chk("t3_b0", got_q[0], {4'd10, 1'b1, 1'b1, 8'h81});

    // 4: truncated payload, then a good packet
    got_q.delete(); errs = 0;
    send_header(4'd6);
    for (int i = 0; i < 5; i++) drive(1'b1, i == 4, 1'b0, i[0], 0, '0, i == 4);
    idle(3);
    chk("t4_errs", errs, 1);
    chk("t4_none", got_q.size(), 0);
    pay_q = '{8'h55};
    send_packet(4'd2, -1, 0);
    idle(3);
    chk("t4_cnt", got_q.size(), 1);
    chk("t4_b0", got_q[0], {4'd2, 1'b1, 1'b1, 8'h55});

    // 5: overflow with consumer stalled
    got_q.delete();
    byte_ready = 1'b0;
    pay_q.delete();
    for (int i = 0; i < 10; i++) pay_q.push_back(8'h10 + 8'(i));
    send_packet(4'd9, -1, 0);
    idle(1);
    @(negedge clock);
    chk("t5_ovf", err_ovf, 1);
    chk("t5_full_valid", byte_valid, 1);
    byte_ready = 1'b1;
    idle(12);
    chk("t5_cnt", got_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      e = {4'd9, (i == 0) ? 1'b1 : 1'b0, 1'b0, 8'h10 + 8'(i)};
      chk("t5_byte", got_q[i], e);
    end

    // 6: reset in the 4th payload byte
    got_q.delete();
    byte_ready = 1'b0;
    send_header(4'd3);
    for (int k = 0; k < 27; k++) begin
      bt = 8'h11 * 8'(k / 8 + 1);
      drive(1'b1, 1'b0, 1'b0, bt[k % 8], (k % 8) == 7, {4'd3, k < 8, 1'b0, bt}, 0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 0);
    idle(1);
    @(negedge clock);
    chk("t6_empty", byte_valid, 0);
    chk("t6_ovf_clr", err_ovf, 0);
    byte_ready = 1'b1;
    pay_q = '{8'h12};
    send_packet(4'd7, -1, 0);
    idle(4);
    chk("t6_cnt", got_q.size(), 1);
    chk("t6_b0", got_q[0], {4'd7, 1'b1, 1'b1, 8'h12});
    chk("end_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
